// File: rtl/regfile_write_bank.sv
// Write side of the 32-entry register file: one-hot write decode, register array
// with r0 tied to zero, and a sequential bulk-clear engine sweeping r1..r31.
module regfile_write_bank #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done,
    output logic [32*WIDTH-1:0]   q_flat
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] regs [1:31];
    logic [31:1]      wr_en;
    logic [31:1]      clr_en;
    logic             accept;

    assign wr_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign accept   = wr_valid && wr_ready;

    // One-hot enables; writes and clears never overlap because writes need IDLE.
    always_comb begin
        wr_en  = '0;
        clr_en = '0;
        for (int k = 1; k < 32; k++) begin
            wr_en[k]  = accept && (wr_addr == 5'(k));
            clr_en[k] = busy && (cnt == 5'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= 5'd1;
                    end
                end
                CLEAR: begin
                    if (cnt == 5'd31) begin
                        state    <= IDLE;
                        cnt      <= 5'd0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < 32; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (clr_en[k]) begin
                    regs[k] <= '0;
                end else if (wr_en[k]) begin
                    regs[k] <= wr_data;
                end
            end
        end
    end

    assign q_flat[WIDTH-1:0] = '0;

    for (genvar k = 1; k < 32; k++) begin : g_flat
        assign q_flat[k*WIDTH +: WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: a register-array model feeds a scoreboard
// queue of expected q_flat images that are popped and compared after each edge.
module tb_regfile_write_bank;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [4:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic            clr_req;
    logic            busy;
    logic            clr_done;
    logic [32*W-1:0] q_flat;

    typedef struct {
        string           tag;
        logic [32*W-1:0] flat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [32];
    int           total;
    int           bad;

    regfile_write_bank #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .q_flat   (q_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32*W-1:0] model_flat();
        logic [32*W-1:0] f;
        for (int k = 0; k < 32; k++) begin
            f[k*W +: W] = model[k];
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_flat(input string tag, input logic [32*W-1:0] obs,
                              input logic [32*W-1:0] exp);
        int first;
        first = 0;
        total++;
        assert (obs === exp) else begin
            bad++;
            for (int k = 31; k >= 0; k--) begin
                if (obs[k*W +: W] !== exp[k*W +: W]) first = k;
            end
            $error("[TB] FAIL %s reg%0d observed=%h expected=%h", tag, first,
                   obs[first*W +: W], exp[first*W +: W]);
        end
    endtask

    // Drives one write for a single edge in IDLE and queues the expected array image.
    task automatic apply_stimulus(input string tag, input logic valid,
                                  input logic [4:0] addr, input logic [W-1:0] data);
        wr_valid = valid;
        wr_addr  = addr;
        wr_data  = data;
        if (valid) check_val({tag, "_ready"}, int'(wr_ready), 1);
        if (valid && addr != 5'd0) model[addr] = data;
        sb.push_back('{tag: tag, flat: model_flat()});
        step();
        wr_valid = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check_flat(e.tag, q_flat, e.flat);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) model[k] = '0;
    endtask

    initial begin
        int cycles;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = '0;
        clr_req  = 1'b0;
        clear_model();

        // Reset for two cycles
        step();
        step();
        rst = 1'b0;
        check_flat("reset_flat", q_flat, '0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_ready", int'(wr_ready), 1);
        check_val("reset_done", int'(clr_done), 0);

        apply_stimulus("wr5", 1'b1, 5'd5, 32'hDEADBEEF);
        check_output();
        apply_stimulus("wr0", 1'b1, 5'd0, 32'hFFFFFFFF);
        check_output();
        apply_stimulus("novalid", 1'b0, 5'd9, 32'hA5A5A5A5);
        check_output();
        apply_stimulus("wr31", 1'b1, 5'd31, 32'h0BADF00D);
        check_output();

        for (int k = 1; k < 32; k++) begin
            apply_stimulus($sformatf("fill%0d", k), 1'b1, 5'(k), W'(k));
            check_output();
        end

        // Bulk clear with a stray clr_req in the middle that must not restart it
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        cycles  = 0;
        while (busy && cycles < 100) begin
            if (clr_done) check_val("done_while_busy", 1, 0);
            if (wr_ready) check_val("ready_while_busy", 1, 0);
            clr_req = (cycles == 5);
            cycles++;
            step();
        end
        clr_req = 1'b0;
        check_val("clear_len", cycles, 31);
        check_val("clear_done_pulse", int'(clr_done), 1);
        check_val("clear_ready", int'(wr_ready), 1);
        clear_model();
        sb.push_back('{tag: "cleared", flat: model_flat()});
        check_output();
        step();
        check_val("clear_done_low", int'(clr_done), 0);
        check_val("clear_busy_low", int'(busy), 0);

        // Write held during a clear is stalled until IDLE, then accepted
        apply_stimulus("pre7", 1'b1, 5'd3, 32'h00000033);
        check_output();
        clr_req = 1'b1;
        step();
        clr_req  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h00001234;
        cycles   = 0;
        while (!wr_ready && cycles < 100) begin
            cycles++;
            step();
        end
        check_val("stall_len", cycles, 31);
        check_val("stall_reg7_zero", int'(q_flat[7*W +: W]), 0);
        clear_model();
        model[7] = 32'h00001234;
        sb.push_back('{tag: "stalled_wr7", flat: model_flat()});
        step();
        wr_valid = 1'b0;
        check_output();

        // Reset on clear cycle 10
        apply_stimulus("pre_rst20", 1'b1, 5'd20, 32'hCAFEF00D);
        check_output();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 1; c < 10; c++) step();
        check_val("mid_clear_busy", int'(busy), 1);
        check_val("mid_clear_r20", int'(q_flat[20*W +: W] == 32'hCAFEF00D), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_mid_busy", int'(busy), 0);
        check_val("rst_mid_done", int'(clr_done), 0);
        check_val("rst_mid_ready", int'(wr_ready), 1);
        check_flat("rst_mid_flat", q_flat, '0);
        step();
        check_val("rst_mid_no_pulse", int'(clr_done), 0);
        clear_model();

        apply_stimulus("post_rst12", 1'b1, 5'd12, 32'h12121212);
        check_output();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
